// File: rtl/baccarat_pkg.sv
// Shared types, constants and helper functions for the baccarat hand datapath.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t       RANK_EMPTY = 4'd0;
  localparam card_t       RANK_ACE   = 4'd1;
  localparam card_t       RANK_KING  = 4'd13;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  // Tens and faces count zero; empty and out-of-range ranks also fall out as zero.
  function automatic card_t card_value(input card_t rank);
    return ((rank > 4'd9) || (rank > RANK_KING)) ? RANK_EMPTY : rank;
  endfunction

  function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
    logic [4:0] sum;
    logic [4:0] rem;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    rem = sum % 5'd10;
    return rem[3:0];
  endfunction

  function automatic card_t lfsr_rank(input logic [15:0] state);
    logic [7:0] rem;
    rem = state[7:0] % 8'd13;
    return rem[3:0] + RANK_ACE;
  endfunction

endpackage

// File: rtl/baccarat_hand_datapath_card_source.sv
// Card source: free-running Galois LFSR mapped to ranks 1..13.
// Optional DEAL_FORCE_EN adds a forced-rank override; the LFSR keeps stepping either way.
module card_source
  import baccarat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        slow_clock,
  input  logic        resetb,
`ifdef DEAL_FORCE_EN
  input  logic        i_force_en,
  input  logic [3:0]  i_force_card,
`endif
  output card_t       o_dealt
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  card_t       w_rank;

  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    w_rank      = lfsr_rank(r_lfsr);
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

`ifdef DEAL_FORCE_EN
  always_comb o_dealt = i_force_en ? i_force_card : w_rank;
`else
  always_comb o_dealt = w_rank;
`endif

endmodule

// File: rtl/baccarat_hand_datapath.sv
// Hand registers, score adders and the player third-card bypass.
// Define DEAL_FORCE_EN to expose force_en/force_card for forced deals.
module baccarat_hand_datapath
  import baccarat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
`ifdef DEAL_FORCE_EN
  input  logic       force_en,
  input  logic [3:0] force_card,
`endif
  output logic [3:0] pcard1_out,
  output logic [3:0] pcard2_out,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1_out,
  output logic [3:0] dcard2_out,
  output logic [3:0] dcard3_out,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  card_t w_dealt;
  card_t r_pcard1, r_pcard2, r_pcard3;
  card_t r_dcard1, r_dcard2, r_dcard3;

  card_source #(
    .SEED(SEED)
  ) u_card_source (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
`ifdef DEAL_FORCE_EN
    .i_force_en  (force_en),
    .i_force_card(force_card),
`endif
    .o_dealt     (w_dealt)
  );

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_pcard1 <= RANK_EMPTY;
      r_pcard2 <= RANK_EMPTY;
      r_pcard3 <= RANK_EMPTY;
      r_dcard1 <= RANK_EMPTY;
      r_dcard2 <= RANK_EMPTY;
      r_dcard3 <= RANK_EMPTY;
    end else begin
      if (load_pcard1) r_pcard1 <= w_dealt;
      if (load_pcard2) r_pcard2 <= w_dealt;
      if (load_pcard3) r_pcard3 <= w_dealt;
      if (load_dcard1) r_dcard1 <= w_dealt;
      if (load_dcard2) r_dcard2 <= w_dealt;
      if (load_dcard3) r_dcard3 <= w_dealt;
    end
  end

  // Bypass lets the controller see the player's third card in the cycle it is dealt.
  always_comb begin
    pcard1_out = r_pcard1;
    pcard2_out = r_pcard2;
    pcard3     = load_pcard3 ? w_dealt : r_pcard3;
    dcard1_out = r_dcard1;
    dcard2_out = r_dcard2;
    dcard3_out = r_dcard3;
    pscore     = hand_score(r_pcard1, r_pcard2, r_pcard3);
    dscore     = hand_score(r_dcard1, r_dcard2, r_dcard3);
  end

endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// Directed self-checking bench for baccarat_hand_datapath; forced-deal scenarios run
// only when DEAL_FORCE_EN is defined.
module tb_baccarat_hand_datapath;

  localparam logic [15:0] SEED = 16'hACE1;

  logic slow_clock = 1'b0;
  logic resetb = 1'b0;
  logic load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
`ifdef DEAL_FORCE_EN
  logic       force_en = 1'b0;
  logic [3:0] force_card = 4'd0;
`endif
  logic [3:0] pcard1_out, pcard2_out, pcard3, dcard1_out, dcard2_out, dcard3_out;
  logic [3:0] pscore, dscore;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [3:0]  m_p[3];
  logic [3:0]  m_d[3];

  baccarat_hand_datapath #(
    .SEED(SEED)
  ) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
`ifdef DEAL_FORCE_EN
    .force_en   (force_en),
    .force_card (force_card),
`endif
    .pcard1_out (pcard1_out),
    .pcard2_out (pcard2_out),
    .pcard3     (pcard3),
    .dcard1_out (dcard1_out),
    .dcard2_out (dcard2_out),
    .dcard3_out (dcard3_out),
    .pscore     (pscore),
    .dscore     (dscore)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic logic [3:0] m_rank(input logic [15:0] s);
    int r;
    r = (int'(s[7:0]) % 13) + 1;
    return 4'(r);
  endfunction

  function automatic int m_val(input logic [3:0] r);
    return (r >= 4'd10) ? 0 : int'(r);
  endfunction

  function automatic logic [3:0] m_score(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
    return 4'((m_val(a) + m_val(b) + m_val(c)) % 10);
  endfunction

  function automatic logic [3:0] m_dealt();
    logic [3:0] d;
    d = m_rank(m_lfsr);
`ifdef DEAL_FORCE_EN
    if (force_en) d = force_card;
`endif
    return d;
  endfunction

  // One rising edge; the model follows the inputs that were stable across it.
  task automatic tick();
    logic [3:0] d;
    d = m_dealt();
    @(posedge slow_clock);
    if (!resetb) begin
      m_lfsr = SEED;
      for (int i = 0; i < 3; i++) begin
        m_p[i] = 4'd0;
        m_d[i] = 4'd0;
      end
    end else begin
      if (load_pcard1) m_p[0] = d;
      if (load_pcard2) m_p[1] = d;
      if (load_pcard3) m_p[2] = d;
      if (load_dcard1) m_d[0] = d;
      if (load_dcard2) m_d[1] = d;
      if (load_dcard3) m_d[2] = d;
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    #1;
  endtask

  task automatic set_load(input int idx, input logic v);
    case (idx)
      0: load_pcard1 = v;
      1: load_pcard2 = v;
      2: load_pcard3 = v;
      3: load_dcard1 = v;
      4: load_dcard2 = v;
      default: load_dcard3 = v;
    endcase
  endtask

  task automatic deal(input int idx);
    set_load(idx, 1'b1);
    tick();
    set_load(idx, 1'b0);
  endtask

  task automatic do_reset(input int n);
    resetb = 1'b0;
    repeat (n) tick();
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] obs[8];
    do_reset(2);
    obs = '{pcard1_out, pcard2_out, pcard3, dcard1_out, dcard2_out, dcard3_out, pscore, dscore};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset_out%0d got %0d want 0", i, obs[i]);
      end
    end
  endtask

  // From SEED ACE1 the first six ranks are 5,9,5,1,1,1.
  task automatic test_lfsr();
    logic [3:0] exp_r[6];
    logic [3:0] obs[6];
    exp_r = '{4'd5, 4'd9, 4'd5, 4'd1, 4'd1, 4'd1};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      set_load(i, 1'b1);
      if (i == 2) begin
        #1;
        checks++;
        if (pcard3 !== 4'd5) begin
          errors++;
          $display("FAIL bypass_pcard3 got %0d want 5", pcard3);
        end
        checks++;
        if (pscore !== 4'd4) begin
          errors++;
          $display("FAIL bypass_pscore_pending got %0d want 4", pscore);
        end
      end
      tick();
      set_load(i, 1'b0);
    end
    obs = '{pcard1_out, pcard2_out, pcard3, dcard1_out, dcard2_out, dcard3_out};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL lfsr_card%0d got %0d want %0d", i, obs[i], exp_r[i]);
      end
      checks++;
      if (obs[i] !== (i < 3 ? m_p[i] : m_d[i - 3])) begin
        errors++;
        $display("FAIL lfsr_model%0d got %0d want %0d", i, obs[i],
                 (i < 3 ? m_p[i] : m_d[i - 3]));
      end
      checks++;
      if (obs[i] < 4'd1 || obs[i] > 4'd13) begin
        errors++;
        $display("FAIL lfsr_range%0d got %0d want 1..13", i, obs[i]);
      end
    end
    checks++;
    if (pscore !== 4'd9) begin
      errors++;
      $display("FAIL lfsr_pscore got %0d want 9", pscore);
    end
    checks++;
    if (dscore !== 4'd3) begin
      errors++;
      $display("FAIL lfsr_dscore got %0d want 3", dscore);
    end
  endtask

  task automatic test_dual_and_hold();
    logic [3:0] obs[6];
    load_pcard1 = 1'b1;
    load_dcard1 = 1'b1;
    tick();
    load_pcard1 = 1'b0;
    load_dcard1 = 1'b0;
    checks++;
    if (pcard1_out !== dcard1_out || pcard1_out !== m_p[0]) begin
      errors++;
      $display("FAIL dual_load got p=%0d d=%0d want %0d", pcard1_out, dcard1_out, m_p[0]);
    end
    repeat (3) tick();
    obs = '{pcard1_out, pcard2_out, pcard3, dcard1_out, dcard2_out, dcard3_out};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== (i < 3 ? m_p[i] : m_d[i - 3])) begin
        errors++;
        $display("FAIL hold_card%0d got %0d want %0d", i, obs[i],
                 (i < 3 ? m_p[i] : m_d[i - 3]));
      end
    end
    deal(1);
    checks++;
    if (pcard2_out !== m_p[1]) begin
      errors++;
      $display("FAIL reload_pcard2 got %0d want %0d", pcard2_out, m_p[1]);
    end
    checks++;
    if (pscore !== m_score(m_p[0], m_p[1], m_p[2])) begin
      errors++;
      $display("FAIL reload_pscore got %0d want %0d", pscore, m_score(m_p[0], m_p[1], m_p[2]));
    end
    checks++;
    if (dscore !== m_score(m_d[0], m_d[1], m_d[2])) begin
      errors++;
      $display("FAIL reload_dscore got %0d want %0d", dscore, m_score(m_d[0], m_d[1], m_d[2]));
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs[8];
    deal(0);
    deal(3);
    // Loads asserted during reset must be ignored.
    load_pcard2 = 1'b1;
    do_reset(1);
    load_pcard2 = 1'b0;
    obs = '{pcard1_out, pcard2_out, pcard3, dcard1_out, dcard2_out, dcard3_out, pscore, dscore};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs[i] !== 4'd0) begin
        errors++;
        $display("FAIL midreset_out%0d got %0d want 0", i, obs[i]);
      end
    end
    deal(0);
    checks++;
    if (pcard1_out !== 4'd5) begin
      errors++;
      $display("FAIL midreset_first_card got %0d want 5", pcard1_out);
    end
  endtask

`ifdef DEAL_FORCE_EN
  task automatic test_force();
    logic [3:0] seq_c[4];
    int         seq_s[4];
    seq_c = '{4'd7, 4'd13, 4'd5, 4'd12};
    seq_s = '{0, 3, 1, 4};
    force_en = 1'b1;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      force_card = seq_c[i];
      deal(seq_s[i]);
    end
    checks++;
    if (pscore !== 4'd2) begin
      errors++;
      $display("FAIL face_pscore got %0d want 2", pscore);
    end
    checks++;
    if (dscore !== 4'd0) begin
      errors++;
      $display("FAIL face_dscore got %0d want 0", dscore);
    end
    do_reset(1);
    force_card = 4'd2;
    deal(0);
    force_card = 4'd3;
    deal(1);
    force_card = 4'd6;
    load_pcard3 = 1'b1;
    #1;
    checks++;
    if (pcard3 !== 4'd6) begin
      errors++;
      $display("FAIL force_bypass_pcard3 got %0d want 6", pcard3);
    end
    checks++;
    if (pscore !== 4'd5) begin
      errors++;
      $display("FAIL force_bypass_pscore got %0d want 5", pscore);
    end
    tick();
    load_pcard3 = 1'b0;
    checks++;
    if (pscore !== 4'd1) begin
      errors++;
      $display("FAIL force_third_pscore got %0d want 1", pscore);
    end
    do_reset(1);
    force_card = 4'd4;
    load_pcard1 = 1'b1;
    load_dcard1 = 1'b1;
    tick();
    load_pcard1 = 1'b0;
    load_dcard1 = 1'b0;
    checks++;
    if (pcard1_out !== 4'd4 || dcard1_out !== 4'd4) begin
      errors++;
      $display("FAIL force_dual got p=%0d d=%0d want 4", pcard1_out, dcard1_out);
    end
    checks++;
    if (pscore !== 4'd4 || dscore !== 4'd4) begin
      errors++;
      $display("FAIL force_dual_score got p=%0d d=%0d want 4", pscore, dscore);
    end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_lfsr();
    test_dual_and_hold();
    test_reset_mid();
`ifdef DEAL_FORCE_EN
    test_force();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
